// File: rtl/four_phase_clock_gen_pkg.sv
// Shared stage/phase types and the stage-to-phase one-hot encoding.
// Pure definitions: no latency, no backpressure.
package qlp_clock_pkg;

   localparam int NUM_STAGES = 4;

   typedef logic [1:0] stage_t;
   typedef logic [0:3] phase_t;

   // Bit 0 of the phase vector is written leftmost, so stage 0 reads as 1000.
   localparam phase_t PH_S0 = 4'b1000;
   localparam phase_t PH_S1 = 4'b0100;
   localparam phase_t PH_S2 = 4'b0010;
   localparam phase_t PH_S3 = 4'b0001;

   function automatic phase_t stage_to_phase(input stage_t stage);
      phase_t ph;
      case (stage)
         2'd0:    ph = PH_S0;
         2'd1:    ph = PH_S1;
         2'd2:    ph = PH_S2;
         default: ph = PH_S3;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/four_phase_clock_gen_if.sv
// Stage sequencer bus: enable in, phase strobes / stage index / wrap out.
// Combinational wires only; enable low freezes the sequence.
interface four_phase_clock_gen_if;
   import qlp_clock_pkg::*;

   logic   enable;
   phase_t clk_phase;
   stage_t clk_stage;
   logic   stage_wrap;

   modport master (input enable, output clk_phase, clk_stage, stage_wrap);
   modport slave  (output enable, input clk_phase, clk_stage, stage_wrap);

endinterface

// File: rtl/four_phase_clock_gen_stage_prescaler.sv
// Counts STAGE_CYCLES enabled cycles per stage; advance pulses on the last one.
// advance is combinational off the count; enable low holds the count.
module stage_prescaler #(
   parameter int STAGE_CYCLES = 2,
   parameter int CNT_W        = $clog2(STAGE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic advance
);

   generate
      if (STAGE_CYCLES < 1) begin : g_bad_stage_cycles
         $error("stage_prescaler: STAGE_CYCLES must be at least 1");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   assign w_at_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (w_at_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Gated by reset so the top can treat advance as "this edge moves the stage".
   assign advance = w_at_last && enable && !reset;

endmodule

// File: rtl/four_phase_clock_gen.sv
// Four-phase one-hot stage sequencer; stage and phase registered on the same edge.
// Outputs change one edge after the prescaler terminal count; enable low freezes all state.
module four_phase_clock_gen
   import qlp_clock_pkg::*;
#(
   parameter int STAGE_CYCLES = 2,
   parameter int CNT_W        = $clog2(STAGE_CYCLES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   four_phase_clock_gen_if.master bus
);

   localparam stage_t LAST_STAGE = stage_t'(NUM_STAGES - 1);

   logic   w_advance;
   stage_t r_stage;
   phase_t r_phase;
   stage_t w_stage_nxt;
   logic   w_stage_wrap;

   stage_prescaler #(
      .STAGE_CYCLES (STAGE_CYCLES),
      .CNT_W        (CNT_W)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .enable  (bus.enable),
      .advance (w_advance)
   );

   // Phase is encoded from the next stage so both registers flip on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage <= '0;
         r_phase <= PH_S0;
      end else begin
         r_stage <= w_stage_nxt;
         r_phase <= stage_to_phase(w_stage_nxt);
      end
   end

   always_comb begin
      w_stage_nxt = r_stage;
      if (w_advance) begin
         w_stage_nxt = r_stage + stage_t'(1);
      end
   end

   always_comb begin
      w_stage_wrap = w_advance && (r_stage == LAST_STAGE);
   end

   assign bus.clk_phase  = r_phase;
   assign bus.clk_stage  = r_stage;
   assign bus.stage_wrap = w_stage_wrap;

endmodule

// File: tb/tb_four_phase_clock_gen.sv
// Directed and random checks of the stage sequencer at STAGE_CYCLES of 2 and 1.
module tb_four_phase_clock_gen;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   four_phase_clock_gen_if if_a ();
   four_phase_clock_gen_if if_b ();

   four_phase_clock_gen #(.STAGE_CYCLES(2)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (if_a.master)
   );

   four_phase_clock_gen #(.STAGE_CYCLES(1)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (if_b.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] ph_tab [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
   int         st_tab [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input bit use_b, input logic [3:0] ph,
                          input int st, input logic wr);
      logic [3:0] p;
      logic [1:0] s;
      logic       w;
      if (use_b) begin
         p = if_b.clk_phase; s = if_b.clk_stage; w = if_b.stage_wrap;
      end else begin
         p = if_a.clk_phase; s = if_a.clk_stage; w = if_a.stage_wrap;
      end
      check({tag, " phase"}, 32'(p), 32'(ph));
      check({tag, " stage"}, 32'(s), 32'(st));
      check({tag, " wrap"},  32'(w), 32'(wr));
   endtask

   function automatic int ph_idx(input logic [3:0] p);
      for (int i = 0; i < 4; i++) begin
         if (p[3-i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(inout int cnt, inout int st, input int sc,
                             input logic rst, input logic en);
      if (rst) begin
         cnt = 0; st = 0;
      end else if (en) begin
         if (cnt == sc - 1) begin
            cnt = 0; st = (st + 1) % 4;
         end else begin
            cnt = cnt + 1;
         end
      end
   endtask

   int ma_cnt, ma_st, mb_cnt, mb_st;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      if_a.enable = 1'b1;
      if_b.enable = 1'b1;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("a reset e%0d", i), 1'b0, 4'b1000, 0, 1'b0);
      end

      // Edge k after release: stage changes on even edges, wrap on edge 7.
      rst_a = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk_out($sformatf("a run e%0d", k), 1'b0, ph_tab[st_tab[k-1]], st_tab[k-1], k == 7);
      end
      tick(); chk_out("a e10", 1'b0, 4'b0100, 1, 1'b0);
      tick(); chk_out("a e11", 1'b0, 4'b0100, 1, 1'b0);
      tick(); chk_out("a e12", 1'b0, 4'b0010, 2, 1'b0);

      if_a.enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out($sformatf("a hold %0d", i), 1'b0, 4'b0010, 2, 1'b0);
      end
      if_a.enable = 1'b1;
      tick(); chk_out("a resume e18", 1'b0, 4'b0010, 2, 1'b0);
      tick(); chk_out("a resume e19", 1'b0, 4'b0001, 3, 1'b0);

      rst_a = 1'b1;
      tick(); chk_out("a midrst", 1'b0, 4'b1000, 0, 1'b0);
      rst_a = 1'b0;
      tick(); chk_out("a post e1", 1'b0, 4'b1000, 0, 1'b0);
      tick(); chk_out("a post e2", 1'b0, 4'b0100, 1, 1'b0);

      chk_out("b reset", 1'b1, 4'b1000, 0, 1'b0);
      rst_b = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_out($sformatf("b e%0d", k), 1'b1, ph_tab[k % 4], k % 4, (k % 4) == 3);
      end

      rst_a = 1'b1;
      rst_b = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         model_step(ma_cnt, ma_st, 2, rst_a, if_a.enable);
         model_step(mb_cnt, mb_st, 1, rst_b, if_b.enable);
         check("rnd a onehot", 32'($onehot(if_a.clk_phase)), 32'd1);
         check("rnd a idx", 32'(ph_idx(if_a.clk_phase)), 32'(int'(if_a.clk_stage)));
         check("rnd a stage", 32'(if_a.clk_stage), 32'(ma_st));
         check("rnd b onehot", 32'($onehot(if_b.clk_phase)), 32'd1);
         check("rnd b idx", 32'(ph_idx(if_b.clk_phase)), 32'(int'(if_b.clk_stage)));
         check("rnd b stage", 32'(if_b.clk_stage), 32'(mb_st));
         rst_a = ($urandom_range(15) == 0);
         rst_b = ($urandom_range(15) == 0);
         if_a.enable = ($urandom_range(3) != 0);
         if_b.enable = ($urandom_range(3) != 0);
         #1;
         check("rnd a wrap", 32'(if_a.stage_wrap),
               32'(ma_st == 3 && ma_cnt == 1 && if_a.enable && !rst_a));
         check("rnd b wrap", 32'(if_b.stage_wrap),
               32'(mb_st == 3 && if_b.enable && !rst_b));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
